// File: rtl/pim_dma_pkg.sv
// pim_dma_pkg: shared types and constants for the PIM DMA engine.
//   - XLEN / PIM_AW / NPIM: data/address width, PIM word-index width, PIM count
//   - dma_state_e: engine FSM states
//   - DMA_M2P / DMA_P2M: funct3 direction encodings
//   - MEM_SIZE_WORD: full-word byte enables
package pim_dma_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned PIM_AW = 13;
   localparam int unsigned NPIM   = 4;
   // One extra bit so a count can reach the maximum size without wrapping.
   localparam int unsigned CNT_W  = PIM_AW + 1;

   localparam logic [2:0] DMA_M2P       = 3'b000;
   localparam logic [2:0] DMA_P2M       = 3'b001;
   localparam logic [3:0] MEM_SIZE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StXfer = 2'd1,
      StDone = 2'd2
   } dma_state_e;

   function automatic logic is_onehot(input logic [NPIM-1:0] v);
      return (v != '0) && ((v & (v - NPIM'(1))) == '0);
   endfunction

endpackage

// File: rtl/pim_dma_ctrl_if.sv
// pim_dma_ctrl_if: command, dmem and PIM signals of the DMA engine.
//   slave  modport: the engine (consumes i_*, drives o_*)
//   master modport: the SoC side (core command, dmem, PIM units)
interface pim_dma_ctrl_if;
   import pim_dma_pkg::*;

   // Core command / status
   logic              i_dma_en;
   logic [2:0]        i_dma_funct3;
   logic [NPIM-1:0]   i_dma_sel_pim;
   logic [PIM_AW-1:0] i_dma_size;
   logic [XLEN-1:0]   i_dma_mem_addr;
   logic              o_dma_busy;
   logic              o_dma_done;
   logic              o_dma_err;
   // dmem arbitration and port
   logic              i_core_req;
   logic              o_core_gnt;
   logic              o_dma_owns_mem;
   logic [XLEN-1:0]   o_mem_addr;
   logic [XLEN-1:0]   o_mem_wr_data;
   logic [3:0]        o_mem_size;
   logic              o_mem_read;
   logic              o_mem_write;
   logic [XLEN-1:0]   i_mem_rd_data;
   // PIM port
   logic [NPIM-1:0]   o_pim_sel;
   logic [PIM_AW-1:0] o_pim_addr;
   logic [XLEN-1:0]   o_pim_wr_data;
   logic              o_pim_read;
   logic              o_pim_write;
   logic [XLEN-1:0]   i_pim_rd_data;

   modport slave (
      input  i_dma_en, i_dma_funct3, i_dma_sel_pim, i_dma_size, i_dma_mem_addr,
      input  i_core_req, i_mem_rd_data, i_pim_rd_data,
      output o_dma_busy, o_dma_done, o_dma_err, o_core_gnt, o_dma_owns_mem,
      output o_mem_addr, o_mem_wr_data, o_mem_size, o_mem_read, o_mem_write,
      output o_pim_sel, o_pim_addr, o_pim_wr_data, o_pim_read, o_pim_write
   );

   modport master (
      output i_dma_en, i_dma_funct3, i_dma_sel_pim, i_dma_size, i_dma_mem_addr,
      output i_core_req, i_mem_rd_data, i_pim_rd_data,
      input  o_dma_busy, o_dma_done, o_dma_err, o_core_gnt, o_dma_owns_mem,
      input  o_mem_addr, o_mem_wr_data, o_mem_size, o_mem_read, o_mem_write,
      input  o_pim_sel, o_pim_addr, o_pim_wr_data, o_pim_read, o_pim_write
   );

endinterface

// File: rtl/dma_hold_reg.sv
// dma_hold_reg: one-entry skid register for PIM->mem transfers.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : drop any held word (new command)
//   load_i/data_i : PIM read data present this cycle
//   pop_i         : word consumed by a dmem write this cycle
//   valid_o/data_o: word available (held, or bypassed straight from the PIM)
module dma_hold_reg
   import pim_dma_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] data_i,
   input  logic            pop_i,
   output logic            valid_o,
   output logic [XLEN-1:0] data_o
);

   logic            hold_v_q, hold_v_d;
   logic [XLEN-1:0] hold_data_q, hold_data_d;

   // Incoming data bypasses the register so an uncontested word costs no
   // extra cycle; it is only captured when the dmem write is blocked.
   always_comb begin
      valid_o     = load_i | hold_v_q;
      data_o      = hold_v_q ? hold_data_q : data_i;
      hold_v_d    = valid_o & ~pop_i & ~clr_i;
      hold_data_d = hold_data_q;
      if (load_i && !hold_v_q) begin
         hold_data_d = data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_v_q    <= 1'b0;
         hold_data_q <= '0;
      end else begin
         hold_v_q    <= hold_v_d;
         hold_data_q <= hold_data_d;
      end
   end

endmodule

// File: rtl/pim_dma_ctrl.sv
// pim_dma_ctrl: word-streaming DMA between dmem and one of NPIM PIM units.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : core command/status, dmem port with core-priority
//                    arbitration, PIM port
module pim_dma_ctrl
   import pim_dma_pkg::*;
(
   input logic           i_clk,
   input logic           i_rst_n,
   pim_dma_ctrl_if.slave bus
);

   dma_state_e       state_q, state_d;
   logic [2:0]       funct3_q;
   logic [NPIM-1:0]  sel_q;
   logic [CNT_W-1:0] size_q;
   logic [XLEN-1:0]  base_q;
   logic             err_q;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic             mem_rd_pend_q;
   logic             pim_rd_pend_q;

   logic             accept, legal, p2m, rd_left;
   logic             mem_read, mem_write, pim_read, pim_write;
   logic             hold_v;
   logic [XLEN-1:0]  hold_data;
   logic [CNT_W-1:0] mem_idx;
   logic [XLEN-1:0]  mem_addr;

   assign accept  = (state_q == StIdle) && bus.i_dma_en;
   assign legal   = ((bus.i_dma_funct3 == DMA_M2P) || (bus.i_dma_funct3 == DMA_P2M)) &&
                    is_onehot(bus.i_dma_sel_pim);
   assign p2m     = (funct3_q == DMA_P2M);
   assign rd_left = (rd_cnt_q < size_q);

   dma_hold_reg u_hold (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .clr_i   (accept),
      .load_i  (pim_rd_pend_q),
      .data_i  (bus.i_pim_rd_data),
      .pop_i   (mem_write),
      .valid_o (hold_v),
      .data_o  (hold_data)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (legal && (bus.i_dma_size != '0)) ? StXfer : StDone;
            end
         end
         StXfer: begin
            if (wr_cnt_d == size_q) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs and transfer strobes
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      pim_read  = 1'b0;
      pim_write = 1'b0;
      if (state_q == StXfer) begin
         if (p2m) begin
            mem_write = hold_v && !bus.i_core_req;
            // Read only if the skid entry is free next cycle.
            pim_read  = rd_left && !(hold_v && !mem_write);
         end else begin
            mem_read  = rd_left && !bus.i_core_req;
            pim_write = mem_rd_pend_q;
         end
      end

      mem_idx  = p2m ? wr_cnt_q : rd_cnt_q;
      mem_addr = base_q + XLEN'({mem_idx, 2'b00});

      bus.o_dma_busy     = (state_q != StIdle);
      bus.o_dma_done     = (state_q == StDone);
      bus.o_dma_err      = (state_q == StDone) && err_q;
      bus.o_core_gnt     = bus.i_core_req;
      bus.o_dma_owns_mem = mem_read || mem_write;
      bus.o_mem_addr     = (mem_read || mem_write) ? mem_addr : '0;
      bus.o_mem_wr_data  = mem_write ? hold_data : '0;
      bus.o_mem_size     = MEM_SIZE_WORD;
      bus.o_mem_read     = mem_read;
      bus.o_mem_write    = mem_write;
      bus.o_pim_sel      = sel_q;
      bus.o_pim_addr     = pim_read  ? rd_cnt_q[PIM_AW-1:0] :
                           pim_write ? wr_cnt_q[PIM_AW-1:0] : '0;
      bus.o_pim_wr_data  = pim_write ? bus.i_mem_rd_data : '0;
      bus.o_pim_read     = pim_read;
      bus.o_pim_write    = pim_write;
   end

   // Word counters
   always_comb begin
      rd_cnt_d = rd_cnt_q + CNT_W'(mem_read || pim_read);
      wr_cnt_d = wr_cnt_q + CNT_W'(mem_write || pim_write);
      if (accept) begin
         rd_cnt_d = '0;
         wr_cnt_d = '0;
      end
   end

   // Command latch and pipeline flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         funct3_q      <= '0;
         sel_q         <= '0;
         size_q        <= '0;
         base_q        <= '0;
         err_q         <= 1'b0;
         rd_cnt_q      <= '0;
         wr_cnt_q      <= '0;
         mem_rd_pend_q <= 1'b0;
         pim_rd_pend_q <= 1'b0;
      end else begin
         if (accept) begin
            funct3_q <= bus.i_dma_funct3;
            sel_q    <= bus.i_dma_sel_pim;
            size_q   <= CNT_W'(bus.i_dma_size);
            base_q   <= bus.i_dma_mem_addr & ~XLEN'(3);
            err_q    <= !legal;
         end
         rd_cnt_q      <= rd_cnt_d;
         wr_cnt_q      <= wr_cnt_d;
         mem_rd_pend_q <= mem_read;
         pim_rd_pend_q <= pim_read;
      end
   end

endmodule

// File: doc/pim_dma_ctrl.md
Name: pim_dma_ctrl

Overview:
- Word-streaming DMA engine between data memory (dmem) and one of four PIM units.
- Launched by the core's DMA command (`dma_en`, `funct3`, `sel_pim`, `size`, `mem_addr`) in EX; reports busy back to the core, which stalls while busy.
- Shares the dmem port with the core; the core always has priority.
- Sits beside the core at SoC top; a top-level mux selects between core and engine dmem signals using `o_dma_owns_mem`.

Parameters:
- XLEN, 32, data/address width
- PIM_AW, 13, PIM word-index width; equals the size field width
- NPIM, 4, number of PIM units (one-hot select width)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_dma_en  in  1  command strobe (1 cycle)
- i_dma_funct3  in  3  000 = mem->PIM; 001 = PIM->mem; others illegal
- i_dma_sel_pim  in  NPIM  one-hot PIM target
- i_dma_size  in  PIM_AW  transfer length in 32-bit words
- i_dma_mem_addr  in  XLEN  dmem byte base address
- o_dma_busy  out  1  engine not idle
- o_dma_done  out  1  1-cycle completion pulse
- o_dma_err  out  1  1-cycle pulse on illegal funct3 or zero/non-one-hot sel_pim
- i_core_req  in  1  core requests dmem
- o_core_gnt  out  1  dmem granted to core
- o_dma_owns_mem  out  1  mux select; engine drives dmem this cycle
- o_mem_addr  out  XLEN  dmem address
- o_mem_wr_data  out  XLEN  dmem write data
- o_mem_size  out  4  byte enables; always 4'b1111
- o_mem_read  out  1  dmem read
- o_mem_write  out  1  dmem write
- i_mem_rd_data  in  XLEN  dmem read data, valid the cycle after the read
- o_pim_sel  out  NPIM  latched one-hot select
- o_pim_addr  out  PIM_AW  PIM word index
- o_pim_wr_data  out  XLEN  PIM write data
- o_pim_read  out  1  PIM read
- o_pim_write  out  1  PIM write
- i_pim_rd_data  in  XLEN  PIM read data, valid the cycle after the read

Behaviour:
- Reset value of every output is 0, except `o_mem_size` = 4'b1111.
  - State returns to IDLE.
  - All counters and the hold-valid flag clear.
  - Reset mid-transfer abandons the transfer; no done or error pulse is generated.
- States and transitions:
  - IDLE: accepts the command when `i_dma_en` = 1.
  - XFER: moves words.
  - DONE: one cycle, then IDLE.
- `o_dma_busy` = (state != IDLE).
- Commands arriving while busy are ignored.
- Command accept at cycle T:
  - Latch funct3, sel_pim, size, and base address; base[1:0] is forced to 00.
  - Zero `rd_cnt` and `wr_cnt`.
  - Next state is XFER if size != 0 and the command is legal; otherwise DONE.
  - An illegal command also asserts `o_dma_err` in the DONE cycle.
- Word i addressing: dmem address = base + 4*i, wrapping modulo 2^XLEN; PIM index = i.
- mem->PIM mode:
  - Issue a dmem read of word `rd_cnt` when `rd_cnt` < size and `i_core_req` = 0.
  - Set `rd_pend` for the next cycle.
  - When `rd_pend` = 1, write PIM index `wr_cnt` with `i_mem_rd_data`; the PIM always accepts.
- PIM->mem mode:
  - Issue a PIM read of word `rd_cnt` when `rd_cnt` < size and the hold register will be empty next cycle.
  - Returned data lands in the hold register (`hold_v` = 1).
  - Write dmem from the hold register when `hold_v` = 1 and `i_core_req` = 0.
- Arbitration:
  - `o_core_gnt` = `i_core_req` in all states.
  - The engine drives dmem only when `i_core_req` = 0; `o_dma_owns_mem` = 1 exactly in cycles where the engine asserts `o_mem_read` or `o_mem_write`.
  - When the core is granted, engine dmem traffic pauses that cycle; no data is lost.
- XFER exits to DONE in the cycle after `wr_cnt` reaches size.
- `o_dma_done` = 1 in the DONE cycle.
- Uncontested N-word transfer timing:
  - Reads at T+1..T+N, writes at T+2..T+N+1.
  - DONE at T+N+2; IDLE at T+N+3.
  - Throughput is 1 word/cycle.
- Counter widths: `rd_cnt` and `wr_cnt` are PIM_AW+1 bits, so the maximum size 8191 does not overflow.

Decomposition:
- `pim_dma_pkg`: state enum (IDLE, XFER, DONE), funct3 constants DMA_M2P=3'b000 and DMA_P2M=3'b001, and the constant MEM_SIZE_WORD=4'b1111.
- One sub-module: `dma_hold_reg`, a one-entry valid/data skid register used in PIM->mem mode.

Test Plan:
- mem->PIM, base 0x1000_0000, size 4, sel 0010, no core traffic -> dmem reads 0x1000_0000..0x1000_000C at T+1..T+4; PIM writes idx 0..3 at T+2..T+5 with matching data; done at T+6; busy T+1..T+6.
- PIM->mem, base 0x2000_0002, size 3, core req high at T+3 -> addresses aligned to 0x2000_0000; engine idle on dmem at T+3 with `o_core_gnt`=1; all 3 words written in order; done one cycle later than uncontested.
- size 0 -> busy at T+1 only; done at T+1; no mem or PIM strobes.
- funct3 3'b101 or sel 0000 -> err and done together at T+1; no transfers.
- Reset asserted mid-transfer at word 2 of 8 -> all outputs 0 immediately; no done pulse; a new command after reset runs normally.
- Base 0xFFFF_FFF8, size 4 -> addresses FFF8, FFFC, 0x0, 0x4 (wrap); `i_dma_en` pulsed while busy is ignored.
